mont_mul_pipe: RTL and testbench

Parametrised, fully pipelined Montgomery modular multiplier. It generalises the fixed q=3329 REDC unit to any odd modulus and width. It adds a per-operation mode (REDC, to-Montgomery, from-Montgomery, full modular multiply), valid/ready flow control with backpressure, and an opaque tag carried alongside each operation. It sits between the NTT/polynomial datapath and its coefficient buffers, and accepts one operation per cycle.

---
 rtl/mont_pkg.sv | 13 +
 rtl/mont_redc3.sv | 68 ++++++
 rtl/mont_mul_pipe.sv | 89 ++++++++
 tb/tb_mont_mul_pipe.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mont_pkg.sv
// Shared types and default constants for the Montgomery multiplier (Kyber q = 3329).
package mont_pkg;
  typedef enum logic [1:0] {
    MODE_REDC      = 2'd0,
    MODE_TO_MONT   = 2'd1,
    MODE_FULL      = 2'd2,
    MODE_FROM_MONT = 2'd3
  } mode_e;

  localparam int Q_KYBER    = 3329;
  localparam int QINV_KYBER = 3327;
  localparam int R2_KYBER   = 2385;
endpackage

// File: rtl/mont_redc3.sv
// Three-stage Montgomery REDC pass: r = x*y*R^-1 mod q, or x delayed unchanged when bypassed.
// The sideband is opaque here and travels in lockstep with the data.
module mont_redc3 import mont_pkg::*; #(
  parameter int WIDTH   = 12,
  parameter int MOD     = Q_KYBER,
  parameter int MOD_INV = QINV_KYBER,
  parameter int SIDE_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              in_valid,
  input  logic              in_bypass,
  input  logic [WIDTH-1:0]  in_x,
  input  logic [WIDTH-1:0]  in_y,
  input  logic [SIDE_W-1:0] in_side,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_r,
  output logic [SIDE_W-1:0] out_side
);
  localparam logic [WIDTH-1:0] QW = MOD[WIDTH-1:0];
  localparam logic [WIDTH-1:0] QI = MOD_INV[WIDTH-1:0];
  localparam logic [WIDTH:0]   QX = {1'b0, QW};

  logic [2:0]             vld_pipe;
  logic [2:0]             byp_pipe;
  logic [2:0][SIDE_W-1:0] side_pipe;
  logic [2*WIDTH-1:0]     t1, t2;
  logic [WIDTH-1:0]       m2, r3;

  logic [WIDTH-1:0]   m;
  logic [2*WIDTH-1:0] mq;
  logic [2*WIDTH:0]   sum;
  logic [WIDTH:0]     u;
  logic [WIDTH-1:0]   red;

  assign m   = t1[WIDTH-1:0] * QI;
  assign mq  = {{WIDTH{1'b0}}, m2} * {{WIDTH{1'b0}}, QW};
  // Low WIDTH bits of sum are zero by construction; u < 2q so one subtract suffices.
  assign sum = {1'b0, t2} + {1'b0, mq};
  assign u   = (WIDTH+1)'(sum >> WIDTH);
  assign red = (u >= QX) ? WIDTH'(u - QX) : WIDTH'(u);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      byp_pipe  <= '0;
      side_pipe <= '0;
      t1        <= '0;
      t2        <= '0;
      m2        <= '0;
      r3        <= '0;
    end else if (en) begin
      vld_pipe  <= {vld_pipe[1:0], in_valid};
      byp_pipe  <= {byp_pipe[1:0], in_bypass};
      side_pipe <= {side_pipe[1:0], in_side};
      t1        <= in_bypass ? {{WIDTH{1'b0}}, in_x}
                             : {{WIDTH{1'b0}}, in_x} * {{WIDTH{1'b0}}, in_y};
      t2        <= t1;
      m2        <= m;
      r3        <= byp_pipe[1] ? t2[WIDTH-1:0] : red;
    end
  end

  assign out_valid = vld_pipe[2];
  assign out_r     = r3;
  assign out_side  = side_pipe[2];
endmodule

// File: rtl/mont_mul_pipe.sv
// Six-stage pipelined Montgomery multiplier: two chained REDC passes with per-op mode and tag.
// Optional range-error flag out_err is enabled by defining MONT_MUL_ERRCHK_EN.
module mont_mul_pipe import mont_pkg::*; #(
  parameter int WIDTH   = 12,
  parameter int MOD     = Q_KYBER,
  parameter int MOD_INV = QINV_KYBER,
  parameter int R2_MOD  = R2_KYBER,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_r,
  output logic [TAG_W-1:0] out_tag
`ifdef MONT_MUL_ERRCHK_EN
  ,
  output logic             out_err
`endif
);
  localparam logic [WIDTH-1:0] R2W = R2_MOD[WIDTH-1:0];
`ifdef MONT_MUL_ERRCHK_EN
  localparam int S1_W = TAG_W + 3;
  localparam int S2_W = TAG_W + 1;
`else
  localparam int S1_W = TAG_W + 2;
  localparam int S2_W = TAG_W;
`endif

  logic             adv;
  mode_e            mode;
  logic [WIDTH-1:0] y_sel;
  logic [S1_W-1:0]  p1_side_in, p1_side;
  logic [S2_W-1:0]  p2_side_in, p2_side;
  logic             p1_valid;
  logic [WIDTH-1:0] p1_r;
  logic             p2_bypass;

  // Whole pipe freezes only when a result is held and not taken.
  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;
  assign mode     = mode_e'(in_mode);

  always_comb begin
    y_sel = in_b;
    case (mode)
      MODE_TO_MONT:   y_sel = R2W;
      MODE_FROM_MONT: y_sel = WIDTH'(1);
      default:        y_sel = in_b;
    endcase
  end

`ifdef MONT_MUL_ERRCHK_EN
  logic err_in;
  localparam logic [WIDTH-1:0] QW = MOD[WIDTH-1:0];
  assign err_in     = (in_a >= QW) ||
                      ((mode == MODE_REDC || mode == MODE_FULL) && (in_b >= QW));
  assign p1_side_in = {err_in, in_mode, in_tag};
  assign p2_side_in = {p1_side[TAG_W+2], p1_side[TAG_W-1:0]};
  assign out_err    = p2_side[TAG_W];
`else
  assign p1_side_in = {in_mode, in_tag};
  assign p2_side_in = p1_side[TAG_W-1:0];
`endif

  assign p2_bypass = mode_e'(p1_side[TAG_W+1:TAG_W]) != MODE_FULL;

  mont_redc3 #(.WIDTH(WIDTH), .MOD(MOD), .MOD_INV(MOD_INV), .SIDE_W(S1_W)) u_p1 (
    .clk(clk), .rst_n(rst_n), .en(adv),
    .in_valid(in_valid), .in_bypass(1'b0),
    .in_x(in_a), .in_y(y_sel), .in_side(p1_side_in),
    .out_valid(p1_valid), .out_r(p1_r), .out_side(p1_side)
  );

  mont_redc3 #(.WIDTH(WIDTH), .MOD(MOD), .MOD_INV(MOD_INV), .SIDE_W(S2_W)) u_p2 (
    .clk(clk), .rst_n(rst_n), .en(adv),
    .in_valid(p1_valid), .in_bypass(p2_bypass),
    .in_x(p1_r), .in_y(R2W), .in_side(p2_side_in),
    .out_valid(out_valid), .out_r(out_r), .out_side(p2_side)
  );

  assign out_tag = p2_side[TAG_W-1:0];
endmodule

// File: tb/tb_mont_mul_pipe.sv
// Scoreboard bench for mont_mul_pipe: driver pushes modelled results, negedge monitor pops and checks.
module tb_mont_mul_pipe;
  localparam int W  = 12;
  localparam int Q  = 3329;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_mode = '0;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_r;
  logic [TW-1:0] out_tag;
`ifdef MONT_MUL_ERRCHK_EN
  logic          out_err;
`endif

  mont_mul_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_tag(out_tag)
`ifdef MONT_MUL_ERRCHK_EN
    , .out_err(out_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int r; int tag; int err; int chk_r; int acc; int st;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0, stalls = 0;
  bit   frz = 1'b0;
  int   rinv = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain modular arithmetic with R = 2^12 and R^-1 mod q.
  function automatic int model(input int mode, input int a, input int b);
    case (mode)
      0:       return (((a * b) % Q) * rinv) % Q;
      1:       return (a * 4096) % Q;
      2:       return (a * b) % Q;
      default: return (a * rinv) % Q;
    endcase
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (frz) stalls++;
  end

  always @(negedge clk) begin
    frz = rst_n && out_valid && !out_ready;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_out: got r=%0d tag=%0d, required no output", out_r, out_tag);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.chk_r != 0) chk("out_r", int'(out_r), mon_e.r);
        chk("out_tag", int'(out_tag), mon_e.tag);
        chk("latency", cyc - mon_e.acc, 5 + stalls - mon_e.st);
`ifdef MONT_MUL_ERRCHK_EN
        chk("out_err", int'(out_err), mon_e.err);
`endif
      end
    end
  end

  task automatic issue(input int mode, input int a, input int b, input int tag);
    exp_t e;
    int n = 0;
    in_valid = 1'b1;
    in_mode  = 2'(mode);
    in_a     = W'(a);
    in_b     = W'(b);
    in_tag   = TW'(tag);
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: in_ready=0 after %0d cycles, required 1", n);
    end else begin
      e.err   = (a >= Q) || ((mode == 0 || mode == 2) && b >= Q);
      e.chk_r = !e.err;
      e.r     = e.err ? 0 : model(mode, a, b);
      e.tag   = tag;
      e.acc   = cyc + 1;
      e.st    = stalls;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    for (int x = 1; x < Q; x++)
      if ((4096 * x) % Q == 1) rinv = x;

    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_r", int'(out_r), 0);
    chk("rst_out_tag", int'(out_tag), 0);
    chk("rst_in_ready", int'(in_ready), 1);
`ifdef MONT_MUL_ERRCHK_EN
    chk("rst_out_err", int'(out_err), 0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed known-answer operations
    issue(3, 767, 0, 1);
    drain();
    issue(1, 1, 0, 2);
    drain();
    issue(0, 767, 767, 3);
    issue(2, 3328, 3328, 4);
    issue(2, 2, 3, 5);
    issue(2, 1234, 0, 6);
    drain();
    chk("kat_redc_model", model(0, 767, 767), 767);
    chk("kat_from_model", model(3, 767, 0), 1);

    // Back-to-back FULL stream with a 3-cycle consumer stall
    fork
      begin
        for (int i = 0; i < 20; i++)
          issue(2, $urandom_range(0, Q - 1), $urandom_range(0, Q - 1), i % 16);
      end
      begin
        for (int k = 0; k < 18; k++) begin
          @(posedge clk); #1;
          out_ready = !(k >= 8 && k <= 10);
          @(negedge clk);
          if (k >= 6 && k <= 14) chk("in_ready_stall", int'(in_ready), (k >= 8 && k <= 10) ? 0 : 1);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Mixed modes back-to-back
    for (int i = 0; i < 12; i++)
      issue($urandom_range(0, 3), $urandom_range(0, Q - 1), $urandom_range(0, Q - 1), i % 16);
    drain();

    // Reset with operations in flight
    for (int i = 0; i < 4; i++)
      issue(2, $urandom_range(0, Q - 1), $urandom_range(0, Q - 1), i + 8);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_out_tag", int'(out_tag), 0);
    sb.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    issue(2, 2, 3, 9);
    drain();

`ifdef MONT_MUL_ERRCHK_EN
    issue(0, 3329, 5, 10);
    issue(1, 5, 4000, 11);
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end
endmodule
